capture_arbiter: RTL and testbench
==================================

# capture_arbiter

Round-robin arbiter that shares one registered capture stage between `NREQ` requesters. Each requester presents a request with a data word. The arbiter accepts one word per cycle into a single-entry output register and hands it downstream with a valid/ready handshake, tagged with the source index. It sits in front of the shared capture flops that all register on the common `clk` with asynchronous `reset`, so that every requester is serviced in one clock domain.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `WIDTH`, 8: data word width, ≥1.
- `TIMEOUT`, 16: stall cycles before a held word is dropped; used only when the timeout feature is compiled in; ≥2.
- `clk` in 1: clock. All logic samples on posedge `clk`.
- `reset` in 1: reset, asynchronous, active-high.
- `req` in `NREQ`: per-requester request; held high with data stable until granted.
- `req_data` in `NREQ*WIDTH`: requester i's word in bits `[i*WIDTH +: WIDTH]`.
- `gnt` out `NREQ`: combinational, one-hot or zero; `gnt[i]` high means requester i's word is taken at this edge.
- `out_valid` out 1: output register holds a word.
- `out_data` out `WIDTH`: captured word.
- `out_src` out `$clog2(NREQ)`: index of the word's requester.
- `out_ready` in 1: downstream accepts the word at this edge when `out_valid` is also high.
- `timeout_err` out 1: registered, one-cycle pulse when a word is dropped; tied to 0 when the feature is compiled out.

## Operation
- Two states:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- Accept condition: `can_take = !out_valid || out_ready`.
- When `can_take` is true and any `req` bit is high, `gnt` selects exactly one requester. Otherwise `gnt`=0.
- Round-robin selection:
  - Search starts at pointer `ptr`, wraps modulo `NREQ`, and picks the first set `req` bit.
  - On each grant, `ptr` becomes (granted index + 1) mod `NREQ`.
  - Without a grant, `ptr` is unchanged.
- On a grant to i:
  - `out_data` ← word i.
  - `out_src` ← i.
  - `out_valid` ← 1.
- Downstream handshake and simultaneous pop and push:
  - FULL with `out_ready`=1 and no grant: `out_valid` ← 0.
  - FULL with `out_ready`=1 and a grant: the register reloads with no bubble and `out_valid` stays 1. Throughput is one word per cycle.
  - FULL with `out_ready`=0: `out_data` and `out_src` hold and `gnt`=0.
- A requester that drops `req` before it is granted is simply skipped. The arbiter never captures an ungranted word.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_src`=0.
  - `ptr`=0, so requester 0 has first priority.
  - `timeout_err`=0 and the stall counter is 0.
- Reset asserted mid-transfer discards any held word immediately (asynchronous clear). `gnt` goes to 0 while `reset` is high.

## Timing
- Latency: a word granted at edge N shows `out_valid`=1 and `out_data` in the cycle after edge N.
- `gnt` is a combinational function of `req`, `ptr`, `out_valid` and `out_ready`, and is valid before the edge at which it takes effect.
- Requesters must not change `req_data[i]` while `req[i]`=1 and `gnt[i]`=0.
- Downstream must keep `out_ready` free of any combinational dependency on `gnt`.
- Fairness: each continuously requesting requester is granted at least once every `NREQ` accepted words.
- Reset deassertion is synchronized externally. The first grant can occur at the first edge after `reset` falls.

## Configuration
- Feature macro: `CAPTURE_ARB_TIMEOUT_EN`.
- Defined:
  - A stall counter increments each cycle that `out_valid`=1 and `out_ready`=0. It clears on any cycle where that condition is false.
  - At the edge where the counter equals `TIMEOUT`-1 with the stall still present, the held word is dropped: `out_valid` ← 0, `timeout_err` ← 1 for one cycle, counter ← 0.
  - No grant occurs at that edge. Grants resume the cycle after.
  - If `out_ready` rises at the same edge the drop would happen, the handshake wins: the word is delivered and no error is raised.
- Undefined: no counter is built and `timeout_err` is constant 0. A word is held indefinitely until `out_ready`.

## Test plan
- Reset, then all `req` high with data 0x10,0x11,0x12,0x13 and `out_ready`=1 → grants go 0,1,2,3,0,… one per cycle; `out_src`/`out_data` follow one cycle later; `out_valid` stays 1 with no bubbles.
- Only `req[2]` high with data 0xA5 and `out_ready`=0 → one grant; `out_valid`=1, `out_data`=0xA5, `out_src`=2, held stable; `gnt`=0 until `out_ready`=1.
- FULL with `out_ready`=1 and `req[1]` high with data 0x3C → pop and reload at the same edge; `out_valid` stays 1 and the next cycle shows 0x3C, src 1.
- Grant to 3, then `req[0]` and `req[3]` both high → requester 0 is granted first (wrap-around), then 3.
- Assert `reset` while FULL, asynchronously between edges → `out_valid`, `out_data` and `out_src` go to 0 immediately; after release, requester 0 has priority.
- With `CAPTURE_ARB_TIMEOUT_EN` and `TIMEOUT`=4: hold `out_ready`=0 → `timeout_err` pulses on the 4th stall edge and `out_valid` drops; repeat with `out_ready` rising on the 4th edge → word delivered, no pulse.

Source files
------------

// File: rtl/capture_arbiter.sv
// capture_arbiter: round-robin arbiter into one registered capture stage; stall timeout via `CAPTURE_ARB_TIMEOUT_EN
module capture_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(NREQ)-1:0]  out_src,
    input  logic                     out_ready,
    output logic                     timeout_err
);
    localparam int SW = $clog2(NREQ);
    localparam logic [SW:0] N = (SW+1)'(NREQ);
    logic [SW-1:0] ptr, off, sel;
    logic [SW:0] sum;
    logic [NREQ-1:0] rot;
    logic any, take, drop;
    logic [WIDTH-1:0] words [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_word
        assign words[i] = req_data[i*WIDTH +: WIDTH];
    end
    assign rot = NREQ'({req, req} >> ptr);
    always_comb begin
        off = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SW'(k);
                any = 1'b1;
            end
        end
    end
    assign sum  = {1'b0, ptr} + {1'b0, off};
    assign sel  = (sum >= N) ? SW'(sum - N) : SW'(sum);
    assign take = any && (!out_valid || out_ready) && !reset;
    assign gnt  = take ? NREQ'(1) << sel : '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= words[sel];
            out_src   <= sel;
            ptr       <= (sel == SW'(NREQ - 1)) ? '0 : sel + 1'b1;
        end else if (out_ready || drop) begin
            out_valid <= 1'b0;
        end
    end
`ifdef CAPTURE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt;
    logic stall;
    assign stall = out_valid && !out_ready;
    assign drop  = stall && (cnt == CW'(TIMEOUT - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= drop;
            cnt         <= (stall && !drop) ? cnt + 1'b1 : '0;
        end
    end
`else
    assign drop        = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_capture_arbiter.sv
// tb_capture_arbiter: directed checks of grant order, handshake, async reset and optional timeout
module tb_capture_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic        timeout_err;
    int checks = 0;
    int errors = 0;

    capture_arbiter #(.NREQ(4), .WIDTH(8), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0; req_data = '0; out_ready = 1'b0;
        tick; tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d expected 0", out_src); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", timeout_err); end
        req = 4'hF; out_ready = 1'b1; #1;
        checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        req = '0;
        @(negedge clk) reset = 1'b0;
        tick;
    endtask

    task automatic test_round_robin;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (gnt !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", i, gnt, 4'(1 << (i % 4))); end
            tick;
            checks++; if (out_valid !== 1'b1 || out_src !== 2'(i % 4) || out_data !== 8'(8'h10 + i % 4))
                begin errors++; $display("FAIL rr_out%0d: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h", i, out_valid, out_src, out_data, i % 4, 8'h10 + i % 4); end
        end
        req = '0; tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_hold;
        req_data = {8'h13, 8'hA5, 8'h11, 8'h10};
        req = 4'b0100; out_ready = 1'b0; #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL hold_gnt: got %b expected 0100", gnt); end
        tick; req = 4'b0001; #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL hold_gnt_blocked: got %b expected 0000", gnt); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2)
                begin errors++; $display("FAIL hold_out%0d: got v=%b src=%0d data=%h expected v=1 src=2 data=a5", i, out_valid, out_src, out_data); end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        req_data = {8'h13, 8'h12, 8'h3C, 8'h10};
        req = 4'b0010; out_ready = 1'b1; #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL b2b_gnt: got %b expected 0010", gnt); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_src !== 2'd1)
            begin errors++; $display("FAIL b2b_out: got v=%b src=%0d data=%h expected v=1 src=1 data=3c", out_valid, out_src, out_data); end
        req = '0; tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_wrap;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1000; #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3: got %b expected 1000", gnt); end
        tick; req = 4'b1001; #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0: got %b expected 0001", gnt); end
        tick;
        checks++; if (out_src !== 2'd0 || out_data !== 8'h10) begin errors++; $display("FAIL wrap_out0: got src=%0d data=%h expected src=0 data=10", out_src, out_data); end
        req = 4'b1000; #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3b: got %b expected 1000", gnt); end
        tick;
        checks++; if (out_src !== 2'd3 || out_data !== 8'h13) begin errors++; $display("FAIL wrap_out3: got src=%0d data=%h expected src=3 data=13", out_src, out_data); end
        req = '0; tick;
    endtask

    task automatic test_async_reset;
        req_data = {8'h13, 8'hA5, 8'h11, 8'h10};
        req = 4'b0100; out_ready = 1'b0;
        tick; req = '0;
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd2) begin errors++; $display("FAIL ares_full: got v=%b src=%0d expected v=1 src=2", out_valid, out_src); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0)
            begin errors++; $display("FAIL ares_clear: got v=%b src=%0d data=%h expected v=0 src=0 data=00", out_valid, out_src, out_data); end
        @(negedge clk) reset = 1'b0;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1001; out_ready = 1'b1; #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ares_prio: got %b expected 0001", gnt); end
        tick;
        checks++; if (out_src !== 2'd0 || out_data !== 8'h10) begin errors++; $display("FAIL ares_out: got src=%0d data=%h expected src=0 data=10", out_src, out_data); end
        req = '0; tick;
    endtask

`ifdef CAPTURE_ARB_TIMEOUT_EN
    task automatic test_timeout;
        req_data = {8'h13, 8'h12, 8'h3C, 8'h10};
        req = 4'b0010; out_ready = 1'b0;
        tick; req = '0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (out_valid !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_stall%0d: got v=%b err=%b expected v=1 err=0", i, out_valid, timeout_err); end
        end
        req = 4'b0001; #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL to_gnt_blocked: got %b expected 0000", gnt); end
        tick;
        checks++; if (out_valid !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_drop: got v=%b err=%b expected v=0 err=1", out_valid, timeout_err); end
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL to_gnt_resume: got %b expected 0001", gnt); end
        tick; req = '0;
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || timeout_err !== 1'b0)
            begin errors++; $display("FAIL to_regrant: got v=%b src=%0d err=%b expected v=1 src=0 err=0", out_valid, out_src, timeout_err); end
        tick; tick; tick;
        out_ready = 1'b1;
        tick;
        checks++; if (out_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_handshake: got v=%b err=%b expected v=0 err=0", out_valid, timeout_err); end
        tick;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_no_pulse: got %b expected 0", timeout_err); end
    endtask
`endif

    initial begin
        test_reset;
        test_round_robin;
        test_hold;
        test_back_to_back;
        test_wrap;
        test_async_reset;
`ifdef CAPTURE_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
